// File: rtl/mbist_pkg.sv
// rtl/mbist_pkg.sv - shared types and march element tables for the MBIST engine
// Purpose: FSM state type, algorithm encodings and the per-element lookup
//          (direction, op count, per-op write-enable and data polarity).
// Ports:   none (package).
package mbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic ALGO_MARCH_CM = 1'b0;
    localparam logic ALGO_MATS_P   = 1'b1;

    // Per-element op description: two = element has a second op,
    // weN = op N is a write, polN = op N uses ~BG instead of BG.
    typedef struct packed {
        logic two;
        logic we0;
        logic pol0;
        logic we1;
        logic pol1;
    } elem_t;

    // March C-: up(w0) up(r0,w1) up(r1,w0) dn(r0,w1) dn(r1,w0) dn(r0)
    // MATS+   : up(w0) up(r0,w1) dn(r1,w0)
    function automatic elem_t elem_lookup(input logic algo, input logic [2:0] idx);
        elem_t e;
        e = '0;
        if (algo == ALGO_MARCH_CM) begin
            unique case (idx)
                3'd0:    e = 5'b01000;
                3'd1:    e = 5'b10011;
                3'd2:    e = 5'b10110;
                3'd3:    e = 5'b10011;
                3'd4:    e = 5'b10110;
                3'd5:    e = 5'b00000;
                default: e = '0;
            endcase
        end else begin
            unique case (idx)
                3'd0:    e = 5'b01000;
                3'd1:    e = 5'b10011;
                3'd2:    e = 5'b10110;
                default: e = '0;
            endcase
        end
        return e;
    endfunction

    // 1 = element walks the address space downwards
    function automatic logic elem_dn(input logic algo, input logic [2:0] idx);
        if (algo == ALGO_MARCH_CM) begin
            return (idx >= 3'd3);
        end
        return (idx == 3'd2);
    endfunction

    function automatic logic [2:0] last_elem(input logic algo);
        return (algo == ALGO_MARCH_CM) ? 3'd5 : 3'd2;
    endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// rtl/mbist_addr_gen.sv - up/down address counter for march elements
// Purpose: holds the current march address, reloads to the start of a new
//          element (0 or DEPTH-1) and flags the last address of the walk.
// Ports:   clk, rst (async, active-high); i_load/i_load_dn reload the start
//          address; i_step advances in direction i_dn; o_addr, o_last.
module mbist_addr_gen #(
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_load_dn,
    input  logic                  i_step,
    input  logic                  i_dn,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] r_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_load_dn ? LAST_ADDR : '0;
        end else if (i_step) begin
            r_addr <= i_dn ? (r_addr - 1'b1) : (r_addr + 1'b1);
        end
    end

    assign o_addr = r_addr;
    assign o_last = i_dn ? (r_addr == '0) : (r_addr == LAST_ADDR);

endmodule

// File: rtl/mbist_march_engine.sv
// rtl/mbist_march_engine.sv - parametrised March C- / MATS+ MBIST engine
// Purpose: issues one march op per cycle to the selected memory, compares
//          read data one cycle later, counts faults against a budget and
//          records the first failing address.
// Ports:   clk, rst; start/algo_sel/bg_sel/memory_sel/error_exceed_ignore/
//          allowable_faulty configure a run; mem_* drive the memories and
//          mem_rdata returns their data; busy/complete/error/force_terminate/
//          fail_count/first_fail_addr report status.
module mbist_march_engine
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 2**ADDR_WIDTH,
    parameter int NUM_MEM    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          algo_sel,
    input  logic                          bg_sel,
    input  logic [2:0]                    memory_sel,
    input  logic                          error_exceed_ignore,
    input  logic [ADDR_WIDTH-1:0]         allowable_faulty,
    output logic [NUM_MEM-1:0]            mem_ce,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [NUM_MEM*DATA_WIDTH-1:0] mem_rdata,
    output logic                          busy,
    output logic                          complete,
    output logic                          error,
    output logic                          force_terminate,
    output logic [ADDR_WIDTH:0]           fail_count,
    output logic [ADDR_WIDTH-1:0]         first_fail_addr
);

    state_t                r_state, w_next;
    logic                  r_algo, r_bg, r_ignore, r_op;
    logic [2:0]            r_mem, r_elem;
    logic [ADDR_WIDTH-1:0] r_budget, r_cmp_addr, r_first;
    logic                  r_cmp_valid, r_error, r_force;
    logic [DATA_WIDTH-1:0] r_cmp_exp;
    logic [ADDR_WIDTH:0]   r_fail;

    elem_t                 w_elem;
    logic                  w_cur_we, w_cur_pol, w_cur_dn, w_next_dn, w_last_op, w_last_elem;
    logic                  w_issue, w_elem_end, w_start_ok, w_sel_bad, w_addr_last;
    logic                  w_load, w_load_dn, w_step, w_miscmp, w_overrun;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH:0]   w_fail_inc;
    logic [DATA_WIDTH-1:0] w_bg, w_data, w_rdata;

    assign w_elem      = elem_lookup(r_algo, r_elem);
    assign w_cur_dn    = elem_dn(r_algo, r_elem);
    assign w_next_dn   = elem_dn(r_algo, r_elem + 3'd1);
    assign w_cur_we    = r_op ? w_elem.we1 : w_elem.we0;
    assign w_cur_pol   = r_op ? w_elem.pol1 : w_elem.pol0;
    assign w_last_op   = !w_elem.two || r_op;
    assign w_last_elem = (r_elem == last_elem(r_algo));
    assign w_issue     = (r_state == ST_RUN);
    assign w_elem_end  = w_issue && w_last_op && w_addr_last;
    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_sel_bad   = ({29'd0, memory_sel} >= 32'(NUM_MEM));

    assign w_bg   = r_bg ? {(DATA_WIDTH/2){2'b10}} : '0;
    assign w_data = w_cur_pol ? ~w_bg : w_bg;

    // A new element reloads its start address in the same cycle its
    // predecessor's last op issues, so elements run back to back.
    assign w_load    = w_start_ok || (w_elem_end && !w_last_elem);
    assign w_load_dn = w_start_ok ? elem_dn(algo_sel, 3'd0) : w_next_dn;
    assign w_step    = w_issue && w_last_op && !w_addr_last;

    mbist_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_load_dn (w_load_dn),
        .i_step    (w_step),
        .i_dn      (w_cur_dn),
        .o_addr    (w_addr),
        .o_last    (w_addr_last)
    );

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_MEM; i++) begin
            if (r_mem == 3'(i)) begin
                w_rdata = mem_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Compare is gated to RUN/DRAIN so a read issued in the abort cycle
    // does not count once the engine has reached DONE.
    assign w_miscmp   = r_cmp_valid && ((r_state == ST_RUN) || (r_state == ST_DRAIN))
                        && (w_rdata != r_cmp_exp);
    assign w_fail_inc = (&r_fail) ? r_fail : (r_fail + 1'b1);
    assign w_overrun  = w_miscmp && !r_ignore && (w_fail_inc > {1'b0, r_budget});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        complete = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                complete = (r_state == ST_DONE);
                if (start) begin
                    w_next = w_sel_bad ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_overrun) begin
                    w_next = ST_DONE;
                end else if (w_elem_end && w_last_elem) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy   = 1'b1;
                w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_algo      <= 1'b0;
            r_bg        <= 1'b0;
            r_mem       <= '0;
            r_ignore    <= 1'b0;
            r_budget    <= '0;
            r_elem      <= '0;
            r_op        <= 1'b0;
            r_cmp_valid <= 1'b0;
            r_cmp_exp   <= '0;
            r_cmp_addr  <= '0;
            r_error     <= 1'b0;
            r_force     <= 1'b0;
            r_fail      <= '0;
            r_first     <= '0;
        end else if (w_start_ok) begin
            r_algo      <= algo_sel;
            r_bg        <= bg_sel;
            r_mem       <= memory_sel;
            r_ignore    <= error_exceed_ignore;
            r_budget    <= allowable_faulty;
            r_elem      <= '0;
            r_op        <= 1'b0;
            r_cmp_valid <= 1'b0;
            r_error     <= w_sel_bad;
            r_force     <= 1'b0;
            r_fail      <= '0;
            r_first     <= '0;
        end else begin
            r_cmp_valid <= w_issue && !w_cur_we;
            r_cmp_exp   <= w_data;
            r_cmp_addr  <= w_addr;
            if (w_issue) begin
                if (!w_last_op) begin
                    r_op <= 1'b1;
                end else begin
                    r_op <= 1'b0;
                    if (w_addr_last) begin
                        r_elem <= r_elem + 3'd1;
                    end
                end
            end
            if (w_miscmp) begin
                r_fail  <= w_fail_inc;
                r_error <= 1'b1;
                if (!r_error) begin
                    r_first <= r_cmp_addr;
                end
            end
            if (w_overrun) begin
                r_force <= 1'b1;
            end
        end
    end

    assign mem_ce          = w_issue ? (NUM_MEM'(1) << r_mem) : '0;
    assign mem_we          = w_issue && w_cur_we;
    assign mem_addr        = w_issue ? w_addr : '0;
    assign mem_wdata       = (w_issue && w_cur_we) ? w_data : '0;
    assign error           = r_error;
    assign force_terminate = r_force;
    assign fail_count      = r_fail;
    assign first_fail_addr = r_first;

endmodule

// File: tb/tb_mbist_march_engine.sv
// tb/tb_mbist_march_engine.sv - scoreboard bench for mbist_march_engine
module tb_mbist_march_engine;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int NM    = 4;

    typedef struct {
        bit we;
        int addr;
        logic [DW-1:0] data;
    } op_t;

    typedef struct {
        int fails;
        bit err;
        bit frc;
        int first;
        int nops;
    } res_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              algo_sel = 1'b0;
    logic              bg_sel = 1'b0;
    logic [2:0]        memory_sel = '0;
    logic              error_exceed_ignore = 1'b0;
    logic [AW-1:0]     allowable_faulty = '0;
    logic [NM-1:0]     mem_ce;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [NM*DW-1:0]  mem_rdata;
    logic              busy, complete, error, force_terminate;
    logic [AW:0]       fail_count;
    logic [AW-1:0]     first_fail_addr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [24:0] exp_ops[$];
    res_t        exp_res[$];

    logic [DW-1:0] mem_arr [NM][DEPTH];
    logic [DW-1:0] sa1     [NM][DEPTH];
    logic [DW-1:0] flip    [NM][DEPTH];
    logic [DW-1:0] rd_q    [NM];

    always #5 clk = ~clk;

    mbist_march_engine #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .NUM_MEM    (NM)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .algo_sel            (algo_sel),
        .bg_sel              (bg_sel),
        .memory_sel          (memory_sel),
        .error_exceed_ignore (error_exceed_ignore),
        .allowable_faulty    (allowable_faulty),
        .mem_ce              (mem_ce),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_rdata           (mem_rdata),
        .busy                (busy),
        .complete            (complete),
        .error               (error),
        .force_terminate     (force_terminate),
        .fail_count          (fail_count),
        .first_fail_addr     (first_fail_addr)
    );

    // Synchronous single-port memories with injectable read faults.
    always @(posedge clk) begin
        for (int m = 0; m < NM; m++) begin
            if (mem_ce[m]) begin
                if (mem_we) mem_arr[m][mem_addr] <= mem_wdata;
                else rd_q[m] <= (mem_arr[m][mem_addr] | sa1[m][mem_addr]) ^ flip[m][mem_addr];
            end
        end
    end
    assign mem_rdata = {rd_q[3], rd_q[2], rd_q[1], rd_q[0]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic clear_faults();
        for (int m = 0; m < NM; m++)
            for (int a = 0; a < DEPTH; a++) begin
                sa1[m][a]  = '0;
                flip[m][a] = '0;
            end
    endtask

    // Reference model: expands the algorithm notation into an op list,
    // replays it on a shadow memory and predicts the DUT's visible result.
    task automatic build_model(input bit algo, input bit bg, input int msel,
                               input int budget, input bit ign);
        string         el[$];
        op_t           seq[$];
        op_t           o;
        logic [DW-1:0] shadow [DEPTH];
        logic [DW-1:0] bgw, got;
        logic [3:0]    ce;
        res_t          r;
        int            nops, nf, first, k;
        bit            abort;
        if (msel >= NM) begin
            r.fails = 0; r.err = 1; r.frc = 0; r.first = 0; r.nops = 0;
            exp_res.push_back(r);
            return;
        end
        if (algo) begin
            el.push_back("Uw0"); el.push_back("Ur0w1"); el.push_back("Dr1w0");
        end else begin
            el.push_back("Uw0"); el.push_back("Ur0w1"); el.push_back("Ur1w0");
            el.push_back("Dr0w1"); el.push_back("Dr1w0"); el.push_back("Dr0");
        end
        bgw = bg ? 16'hAAAA : 16'h0000;
        foreach (el[e]) begin
            nops = (el[e].len() - 1) / 2;
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < nops; j++) begin
                    o.addr = (el[e].substr(0, 0) == "D") ? DEPTH - 1 - i : i;
                    o.we   = (el[e].substr(1 + 2*j, 1 + 2*j) == "w");
                    o.data = (el[e].substr(2 + 2*j, 2 + 2*j) == "1") ? ~bgw : bgw;
                    seq.push_back(o);
                end
            end
        end
        for (int a = 0; a < DEPTH; a++) shadow[a] = '0;
        nf = 0; first = 0; abort = 0;
        r.nops = seq.size();
        for (k = 0; k < seq.size() && !abort; k++) begin
            if (seq[k].we) begin
                shadow[seq[k].addr] = seq[k].data;
            end else begin
                got = (shadow[seq[k].addr] | sa1[msel][seq[k].addr]) ^ flip[msel][seq[k].addr];
                if (got != seq[k].data) begin
                    if (nf == 0) first = seq[k].addr;
                    if (nf < 31) nf++;
                    // Budget overrun: the op after the failing read still issues.
                    if (!ign && nf > budget) begin
                        abort  = 1;
                        r.nops = (k + 2 < seq.size()) ? k + 2 : seq.size();
                    end
                end
            end
        end
        ce = 4'b0001 << msel;
        for (int i = 0; i < r.nops; i++)
            exp_ops.push_back({ce, seq[i].we, 4'(seq[i].addr), seq[i].we ? seq[i].data : 16'h0});
        r.fails = nf; r.err = (nf > 0); r.frc = abort; r.first = first;
        exp_res.push_back(r);
    endtask

    // Monitor: pops expectations whenever the DUT issues an op or completes.
    int   mon_ops = 0;
    bit   prev_complete = 0;
    res_t mr;
    always @(negedge clk) begin
        if (rst) begin
            mon_ops = 0;
            prev_complete = 0;
        end else begin
            if (mem_ce != '0) begin
                mon_ops++;
                if (exp_ops.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_op: ce=0x%0h addr=0x%0h", mem_ce, mem_addr);
                end else begin
                    check("op", {7'd0, mem_ce, mem_we, mem_addr, mem_we ? mem_wdata : 16'h0},
                          {7'd0, exp_ops.pop_front()});
                end
            end
            if (complete && !prev_complete) begin
                if (exp_res.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_complete: fail_count=%0d", fail_count);
                end else begin
                    mr = exp_res.pop_front();
                    check("fail_count", 32'(fail_count), 32'(mr.fails));
                    check("error", 32'(error), 32'(mr.err));
                    check("force_terminate", 32'(force_terminate), 32'(mr.frc));
                    check("first_fail_addr", 32'(first_fail_addr), 32'(mr.first));
                    check("op_count", 32'(mon_ops), 32'(mr.nops));
                    check("busy_at_done", 32'(busy), 32'd0);
                end
                mon_ops = 0;
            end
            prev_complete = complete;
        end
    end

    task automatic pulse_start(input bit algo, input bit bg, input int msel,
                               input int budget, input bit ign);
        @(posedge clk); #1;
        algo_sel = algo; bg_sel = bg; memory_sel = 3'(msel);
        allowable_faulty = AW'(budget); error_exceed_ignore = ign;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        while (exp_res.size() != 0 && cyc < 400) begin
            @(posedge clk);
            cyc++;
        end
        if (exp_res.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL timeout_%s: no completion within 400 cycles", name);
            exp_res.delete();
            exp_ops.delete();
        end
        @(posedge clk);
    endtask

    task automatic run(input string name, input bit algo, input bit bg, input int msel,
                       input int budget, input bit ign);
        build_model(algo, bg, msel, budget, ign);
        pulse_start(algo, bg, msel, budget, ign);
        wait_done(name);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ce"}, 32'(mem_ce), 32'd0);
        check({name, "_we_addr_wdata"}, {11'd0, mem_we, mem_addr, mem_wdata}, 32'd0);
        check({name, "_status"}, {28'd0, busy, complete, error, force_terminate}, 32'd0);
        check({name, "_counts"}, {23'd0, fail_count, first_fail_addr}, 32'd0);
    endtask

    task automatic random_runs(input int n);
        for (int t = 0; t < n; t++) begin
            bit algo, bg, ign;
            int msel, budget, nflt, a;
            algo = 1'($urandom_range(0, 1));
            bg   = 1'($urandom_range(0, 1));
            ign  = 1'($urandom_range(0, 1));
            msel = $urandom_range(0, NM - 1);
            budget = $urandom_range(0, 4);
            nflt = $urandom_range(0, 3);
            clear_faults();
            for (int f = 0; f < nflt; f++) begin
                a = $urandom_range(0, DEPTH - 1);
                if ($urandom_range(0, 1) == 1) sa1[msel][a]  = DW'(1) << $urandom_range(0, DW - 1);
                else                           flip[msel][a] = DW'(1) << $urandom_range(0, DW - 1);
            end
            run("random", algo, bg, msel, budget, ign);
        end
    endtask

    initial begin
        clear_faults();
        #3 rst = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Out-of-range memory select from IDLE: immediate DONE, no accesses.
        run("bad_sel", 1'b0, 1'b0, 5, 0, 1'b0);

        // Fault-free March C-, solid background.
        run("mcm_clean", 1'b0, 1'b0, 0, 0, 1'b0);

        // MATS+, memory 2 stuck-at-1 bit 5 at address 7.
        clear_faults();
        sa1[2][7] = 16'h0020;
        run("mats_sa1", 1'b1, 1'b0, 2, 3, 1'b0);

        // March C-, faults at 2/4/9, budget 1: abort after 2nd miscompare.
        clear_faults();
        flip[0][2] = 16'h0001; flip[0][4] = 16'h0100; flip[0][9] = 16'h8000;
        run("mcm_abort", 1'b0, 1'b0, 0, 1, 1'b0);

        // Same faults with overrun ignored: full run, 15 miscompares.
        run("mcm_ignore", 1'b0, 1'b0, 0, 1, 1'b1);

        // Checkerboard background, clean, with a start pulse mid-run.
        clear_faults();
        build_model(1'b0, 1'b1, 1, 0, 1'b0);
        pulse_start(1'b0, 1'b1, 1, 0, 1'b0);
        repeat (20) @(posedge clk);
        pulse_start(1'b1, 1'b0, 3, 0, 1'b1);
        wait_done("start_while_busy");

        random_runs(8);

        // Reset after 40 ops, then a fresh run from scratch.
        clear_faults();
        build_model(1'b0, 1'b0, 3, 0, 1'b0);
        pulse_start(1'b0, 1'b0, 3, 0, 1'b0);
        repeat (39) @(posedge clk);
        #1 rst = 1'b1;
        exp_ops.delete();
        exp_res.delete();
        #1 check_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run("after_reset", 1'b1, 1'b1, 3, 0, 1'b0);

        repeat (3) @(posedge clk);
        check("leftover_ops", 32'(exp_ops.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
